// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: the arbiter's FIFO-side signals. DUT sits on the slave
// modport; the environment driving the input/output FIFO flags uses master.
interface vc_arbiter_if #(
  parameter int DATA_W    = 12,
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0]        in_empty;
  logic [NUM_LANES*DATA_W-1:0] in_data;
  logic [NUM_LANES-1:0]        out_almost_full;
  logic [NUM_LANES-1:0]        pop;
  logic [NUM_LANES-1:0]        push;
  logic [DATA_W-1:0]           data_out;
  logic [1:0]                  arb_state;
  logic [7:0]                  word_count;

  modport master (
    output in_empty, in_data, out_almost_full,
    input  pop, push, data_out, arb_state, word_count
  );

  modport slave (
    input  in_empty, in_data, out_almost_full,
    output pop, push, data_out, arb_state, word_count
  );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: 4-in / 4-out transaction arbiter between the per-class input
// FIFOs and the per-destination output FIFOs. Grants one input per cycle,
// pops it, captures the returned word one cycle later and pushes it to the
// output FIFO named by the word's top two bits.
// Optional build macro: VC_ARB_STRICT_PRI_EN selects fixed priority
// (input 0 highest) instead of round-robin.

// Per-lane slice: eligibility and the masked capture contribution.
module vc_arb_lane #(
  parameter int DATA_W    = 12,
  parameter int NUM_LANES = 4
) (
  input  logic                 empty,
  input  logic                 prev_grant,
  input  logic                 sel,
  input  logic [DATA_W-1:0]    data,
  output logic                 elig,
  output logic [DATA_W-1:0]    cap_data,
  output logic [NUM_LANES-1:0] cap_push
);
  localparam int DEST_W = $clog2(NUM_LANES);

  logic [DEST_W-1:0] dest;

  assign dest     = data[DATA_W-1 -: DEST_W];
  // The empty flag lags a pop by one cycle, so the lane granted last cycle
  // must sit out this one.
  assign elig     = ~empty & ~prev_grant;
  assign cap_data = sel ? data : '0;

  // Destination one-hot, only when this lane's word is being captured.
  always_comb begin
    cap_push = '0;
    if (sel) cap_push[dest] = 1'b1;
  end
endmodule

module vc_arbiter #(
  parameter int DATA_W = 12
) (
  input logic         clk,
  input logic         reset,
  vc_arbiter_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int PTR_W     = 2;
  localparam int STAGES    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0] push;
    logic [DATA_W-1:0]    data;
  } cap_t;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_cap_data;
  logic [NUM_LANES-1:0][NUM_LANES-1:0] lane_cap_push;
  logic [NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] pop_q;
  logic [NUM_LANES-1:0] sel_q;
  logic [NUM_LANES-1:0] push_q;
  logic [DATA_W-1:0]    data_q;
  logic [7:0]           cnt_q;
  logic [PTR_W-1:0]     rr_ptr, rr_d;
  logic [STAGES:0]      vld_pipe;
  state_t               state_q, state_d;
  cap_t                 cap;
  logic                 stall;
  logic                 any_req;

  assign lane_data = bus.in_data;
  assign stall     = |bus.out_almost_full;
  assign any_req   = |(~bus.in_empty);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      vc_arb_lane #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) u_lane (
        .empty      (bus.in_empty[gi]),
        .prev_grant (pop_q[gi]),
        .sel        (sel_q[gi]),
        .data       (lane_data[gi]),
        .elig       (elig[gi]),
        .cap_data   (lane_cap_data[gi]),
        .cap_push   (lane_cap_push[gi])
      );
    end
  endgenerate

  // sel_q is one-hot or zero, so OR-ing the masked lanes is an exact mux.
  always_comb begin
    cap = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cap.data = cap.data | lane_cap_data[i];
      cap.push = cap.push | lane_cap_push[i];
    end
  end

  // Grant search from rr_ptr (held at 0 in strict mode) and next FSM state.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant   = '0;
    rr_d    = rr_ptr;
    state_d = IDLE;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = rr_ptr + PTR_W'(k);
      if (!found && !stall && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
`ifdef VC_ARB_STRICT_PRI_EN
        rr_d       = '0;
`else
        rr_d       = idx + 1'b1;
`endif
      end
    end
    if (stall && any_req) state_d = STALL;
    else if (found)       state_d = ARB;
    else                  state_d = IDLE;
  end

  // Pop/capture pipeline, pointer and FSM state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q    <= '0;
      sel_q    <= '0;
      push_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      rr_ptr   <= '0;
      vld_pipe <= '0;
      state_q  <= IDLE;
    end else begin
      pop_q    <= grant;
      sel_q    <= pop_q;
      vld_pipe <= {vld_pipe[STAGES-1:0], |grant};
      rr_ptr   <= rr_d;
      state_q  <= state_d;
      // vld_pipe[STAGES] mirrors |sel_q: the popped word is on in_data now.
      if (vld_pipe[STAGES]) begin
        push_q <= cap.push;
        data_q <= cap.data;
        cnt_q  <= cnt_q + 8'd1;
      end else begin
        push_q <= '0;
      end
    end
  end

  assign bus.pop        = pop_q;
  assign bus.push       = push_q;
  assign bus.data_out   = data_q;
  assign bus.arb_state  = state_q;
  assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed, cycle-by-cycle checks of vc_arbiter.
module tb_vc_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  vc_arbiter_if #(.DATA_W(12)) bus ();

  vc_arbiter #(.DATA_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  rr_pop  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0]  rr_push [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [11:0] rr_data [5] = '{12'h000, 12'h0AA, 12'h4BB, 12'h8CC, 12'hCDD};
  logic [7:0]  rr_cnt  [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};

  logic [3:0]  sr_pop  [7] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
  logic [3:0]  sr_push [7] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
  logic [7:0]  sr_cnt  [7] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};

`ifdef VC_ARB_STRICT_PRI_EN
  logic [3:0]  alt_pop [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
  logic [3:0]  alt_pop [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
`endif

  initial begin
    reset                = 1'b0;
    bus.in_empty         = 4'b0000;
    bus.out_almost_full  = 4'b0000;
    bus.in_data          = {12'hCDD, 12'h8CC, 12'h4BB, 12'h0AA};

    // Reset held two cycles with every input non-empty.
    step();
    step();
    chk("rst_pop",   {12'd0, bus.pop},        16'h0);
    chk("rst_push",  {12'd0, bus.push},       16'h0);
    chk("rst_data",  {4'd0, bus.data_out},    16'h0);
    chk("rst_cnt",   {8'd0, bus.word_count},  16'h0);
    chk("rst_state", {14'd0, bus.arb_state},  16'h0);

    // First pop one cycle after release.
    reset = 1'b1;
    step();
    chk("rel_pop",   {12'd0, bus.pop},       16'h1);
    chk("rel_state", {14'd0, bus.arb_state}, 16'h1);

    // Round-robin over four busy inputs.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_pop",  {12'd0, bus.pop},       {12'd0, rr_pop[i]});
      chk("rr_push", {12'd0, bus.push},      {12'd0, rr_push[i]});
      chk("rr_data", {4'd0, bus.data_out},   {4'd0, rr_data[i]});
      chk("rr_cnt",  {8'd0, bus.word_count}, {8'd0, rr_cnt[i]});
    end

    // Stall: pops stop, two in-flight words still drain.
    bus.out_almost_full = 4'b0010;
    step();
    chk("st0_pop",   {12'd0, bus.pop},       16'h0);
    chk("st0_state", {14'd0, bus.arb_state}, 16'h2);
    chk("st0_push",  {12'd0, bus.push},      16'h1);
    chk("st0_data",  {4'd0, bus.data_out},   16'h0AA);
    step();
    chk("st1_pop",   {12'd0, bus.pop},       16'h0);
    chk("st1_push",  {12'd0, bus.push},      16'h2);
    chk("st1_data",  {4'd0, bus.data_out},   16'h4BB);
    chk("st1_cnt",   {8'd0, bus.word_count}, 16'd6);
    step();
    chk("st2_push",  {12'd0, bus.push},      16'h0);
    chk("st2_data",  {4'd0, bus.data_out},   16'h4BB);
    chk("st2_cnt",   {8'd0, bus.word_count}, 16'd6);
    chk("st2_state", {14'd0, bus.arb_state}, 16'h2);

    // Release: resume at saved pointer (input 2).
    bus.out_almost_full = 4'b0000;
    step();
    chk("res_pop",   {12'd0, bus.pop},       16'h4);
    chk("res_state", {14'd0, bus.arb_state}, 16'h1);
    step();
    chk("res_pop2",  {12'd0, bus.pop},       16'h8);

    // Reset while pop (1000) and sel_q (0100) are both live.
    reset = 1'b0;
    step();
    chk("mrst_pop",   {12'd0, bus.pop},       16'h0);
    chk("mrst_push",  {12'd0, bus.push},      16'h0);
    chk("mrst_cnt",   {8'd0, bus.word_count}, 16'h0);
    chk("mrst_data",  {4'd0, bus.data_out},   16'h0);
    chk("mrst_state", {14'd0, bus.arb_state}, 16'h0);
    reset        = 1'b1;
    bus.in_empty = 4'b1111;
    bus.in_data  = {12'hCDD, 12'hC12, 12'h4BB, 12'h0AA};
    step();
    chk("mrst_push2", {12'd0, bus.push},      16'h0);
    chk("mrst_cnt2",  {8'd0, bus.word_count}, 16'h0);

    // Single requester: input 2, word destined for output 3.
    bus.in_empty = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("sr_pop",  {12'd0, bus.pop},       {12'd0, sr_pop[i]});
      chk("sr_push", {12'd0, bus.push},      {12'd0, sr_push[i]});
      chk("sr_cnt",  {8'd0, bus.word_count}, {8'd0, sr_cnt[i]});
      if (i == 5) bus.in_empty = 4'b1111;
    end
    chk("sr_data",  {4'd0, bus.data_out},   16'hC12);
    chk("sr_state", {14'd0, bus.arb_state}, 16'h0);

    // Almost-full with nothing to pop stays IDLE.
    bus.out_almost_full = 4'b0100;
    step();
    chk("afe_state", {14'd0, bus.arb_state}, 16'h0);
    chk("afe_pop",   {12'd0, bus.pop},       16'h0);

    // Inputs 1 and 3 both busy: grants alternate.
    bus.out_almost_full = 4'b0000;
    bus.in_empty        = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_pop", {12'd0, bus.pop}, {12'd0, alt_pop[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Four-to-four transaction arbiter placed between the per-class input FIFOs and the per-destination output FIFOs of the PCIe transaction layer. It grants one non-empty input FIFO per cycle (round-robin), pops it, captures the returned 12-bit word and pushes it into the output FIFO selected by the word's destination field. It throttles all pops while any output FIFO reports almost-full.

## Interface
- DATA_W, 12, word width; destination field is bits [DATA_W-1:DATA_W-2]
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_empty  in  4  per-input FIFO empty flag, bit i = input i
- in_data  in  4*DATA_W  input FIFO read data, lane i at [i*DATA_W +: DATA_W]
- out_almost_full  in  4  per-output FIFO almost-full flag
- pop  out  4  registered pop strobes to input FIFOs, one-hot or zero
- push  out  4  registered push strobes to output FIFOs, one-hot or zero
- data_out  out  DATA_W  registered word accompanying push
- arb_state  out  2  FSM state: 0 IDLE, 1 ARB, 2 STALL
- word_count  out  8  count of pushes issued, wraps 255->0

## Operation
- Eligibility: input i is eligible when in_empty[i]=0 and i was not granted in the previous cycle. The previous-grant mask covers the one-cycle lag of the FIFO empty flag.
- Round-robin: rr_ptr (2 bits) names the highest-priority input. Search order is rr_ptr, rr_ptr+1, ... mod 4. The first eligible input is granted and rr_ptr becomes grant+1 mod 4. rr_ptr holds when nothing is granted.
- Stall: when out_almost_full != 0 at an edge, no pop is issued for the following cycle. Words already in flight (at most 2) still push. The downstream almost-full slack absorbs them.
- FSM, evaluated at each edge:
  - STALL if out_almost_full != 0 and any in_empty=0.
  - Otherwise ARB if a grant is made.
  - Otherwise IDLE.
- Capture: sel_q records the pop one-hot one cycle later. When sel_q[i]=1:
  - data_out <= in_data lane i
  - push <= one-hot of in_data lane i bits [DATA_W-1:DATA_W-2]
  - word_count increments
- When sel_q=0, push <= 0 and data_out holds.
- Reset (reset=0 at an edge), including mid-operation:
  - pop, push, sel_q, rr_ptr, previous-grant mask all cleared to 0
  - data_out=0, word_count=0, arb_state=IDLE
  - in-flight words are discarded

## Timing
- Grant decided from inputs sampled at edge E. pop is high for cycle E..E+1.
- The input FIFO updates its read data at edge E+1. sel_q is valid in cycle E+1.
- push and data_out are high/valid in cycle E+2. Pop-to-push latency is 2 cycles.
- Throughput:
  - with two or more inputs eligible, 1 word per cycle
  - with a single input eligible, 1 word per 2 cycles, due to the previous-grant mask
- pop and push are never more than one-hot.
- A word destined to any output is pushed even if that output asserts almost-full after the pop.
- Stall takes effect on the pop driven in the cycle after out_almost_full is sampled high.
- Deasserting all of out_almost_full allows a pop in the next cycle.

## Configuration
- VC_ARB_STRICT_PRI_EN
  - Defined: fixed priority, input 0 highest, input 3 lowest. rr_ptr is unused and held at 0. The previous-grant mask still applies.
  - Undefined (default): round-robin as described.

## Test plan
- Reset:
  - Drive reset=0 for 2 cycles with all inputs non-empty -> pop=0, push=0, data_out=0, word_count=0, arb_state=0.
  - Release reset -> first pop=4'b0001 one cycle after release.
- Round-robin:
  - Drive in_empty=0000; lane data 12'h0AA, 12'h4BB, 12'h8CC, 12'hCDD (destinations 0,1,2,3) -> pop sequence 0001,0010,0100,1000,0001.
  - push sequence 0001,0010,0100,1000, each 2 cycles after its pop, with data_out matching the lane data.
- Single requester:
  - Only input 2 non-empty for 6 cycles -> pop=0100 every other cycle.
  - push=one-hot of the word's destination every other cycle.
  - word_count=3 after the last push.
- Stall:
  - Assert out_almost_full=0010 mid-stream -> pops stop from the next cycle and arb_state=2.
  - In-flight ≤2 words still push.
  - Deassert -> pops resume from the saved rr_ptr.
- Reset mid-operation:
  - Assert reset=0 while pop and sel_q are both active -> push=0 on the following cycle; the in-flight word is never pushed; word_count=0.
- Strict priority (VC_ARB_STRICT_PRI_EN defined):
  - Inputs 1 and 3 continuously non-empty -> grants alternate 0010,1000 (input 1 masked every other cycle).
  - Input 3 never starves only because of the previous-grant mask.
